// File: rtl/clap_pkg.sv
// ---------------------------------------------------------------------------
// clap_pkg
// Shared definitions for the clap detection front end: the detector state
// encoding and the default width of the burst/hold-off counter.
// ---------------------------------------------------------------------------
package clap_pkg;

  // Default counter width; wide enough for hold-off periods of tens of ms.
  localparam int unsigned CLAP_CNT_W = 16;

  // Detector states:
  //   IDLE     - waiting for the synchronised mic to go high
  //   HIGH     - measuring the length of a burst
  //   WAIT_LOW - burst too long (or already running); waiting for it to end
  //   HOLD     - refractory period, input ignored
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HIGH     = 2'd1,
    WAIT_LOW = 2'd2,
    HOLD     = 2'd3
  } clap_state_e;

endpackage

// File: rtl/clap_detector_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset, clears both stages
//   d_i    - asynchronous input bit
//   q_o    - synchronised output, two clk_i cycles behind d_i
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // The first stage may go metastable; the second stage gives it a full
  // cycle to resolve before anything downstream looks at the value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clap_detector.sv
// ---------------------------------------------------------------------------
// clap_detector
// Turns a raw thresholded microphone comparator into one clean clap pulse
// per burst of legal length. Short bursts are dropped as glitches, long ones
// are flagged as noise, and every burst is followed by a hold-off period so
// room echoes are not counted as extra claps.
// Ports:
//   clk_i    - system clock
//   rst_i    - synchronous active-high reset
//   mic_i    - raw comparator output, asynchronous to clk_i
//   clap_o   - one-cycle pulse per accepted clap
//   reject_o - one-cycle pulse when a burst runs past MAX_HIGH
//   busy_o   - high whenever the detector is not idle
// ---------------------------------------------------------------------------
module clap_detector
  import clap_pkg::*;
#(
  parameter int unsigned CNT_W    = CLAP_CNT_W,
  parameter int unsigned MIN_HIGH = 1000,
  parameter int unsigned MAX_HIGH = 20000,
  parameter int unsigned HOLDOFF  = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mic_i,
  output logic clap_o,
  output logic reject_o,
  output logic busy_o
);

  // Refuse to build with thresholds the counter cannot represent or that
  // make no sense relative to each other.
  if (!(MIN_HIGH >= 1 && MIN_HIGH <= MAX_HIGH &&
        64'(MAX_HIGH) < (64'd1 << CNT_W) &&
        HOLDOFF >= 1 && 64'(HOLDOFF) < (64'd1 << CNT_W))) begin : g_bad_params
    $error("clap_detector: illegal MIN_HIGH/MAX_HIGH/HOLDOFF for CNT_W");
  end

  localparam logic [CNT_W-1:0] MinCnt  = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] HoldEnd = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic        s_mic;
  clap_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        clap_q, clap_d;
  logic        reject_q, reject_d;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (mic_i),
    .q_o   (s_mic)
  );

  // State, counter and the two registered pulse outputs. Reset wins every
  // cycle it is asserted, so a burst interrupted by reset never pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      clap_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clap_q   <= clap_d;
      reject_q <= reject_d;
    end
  end

  // Next-state logic. The single counter is reused: in HIGH it holds the
  // number of high samples seen so far, in HOLD the cycles already spent
  // ignoring input. It saturates naturally at MAX_HIGH / HOLDOFF-1 because
  // both of those values force a state change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clap_d   = 1'b0;
    reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_mic) begin
          state_d = HIGH;
          cnt_d   = CntOne;
        end else begin
          cnt_d   = '0;
        end
      end
      HIGH: begin
        if (s_mic) begin
          // This sample is number MAX_HIGH+1: the burst is noise.
          if (cnt_q == MaxCnt) begin
            state_d  = WAIT_LOW;
            reject_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else if (cnt_q >= MinCnt) begin
          state_d = HOLD;
          cnt_d   = '0;
          clap_d  = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (!s_mic) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // A burst still running when the hold-off expires is waited out
        // rather than measured from its middle.
        if (cnt_q == HoldEnd) begin
          state_d = s_mic ? WAIT_LOW : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clap_o   = clap_q;
  assign reject_o = reject_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_clap_detector.sv
// ---------------------------------------------------------------------------
// tb_clap_detector
// Self-checking bench for clap_detector with MIN_HIGH=3, MAX_HIGH=8,
// HOLDOFF=5. The whole mic/reset stream is built first (directed scenarios
// followed by random bursts), the expected per-cycle outputs are derived from
// the burst rules by scanning that stream, and the DUT is then driven cycle
// by cycle and compared.
// ---------------------------------------------------------------------------
module tb_clap_detector;

  localparam int MinHigh = 3;
  localparam int MaxHigh = 8;
  localparam int Holdoff = 5;
  localparam int MaxN    = 4000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic mic_i = 1'b0;
  logic clap_o;
  logic reject_o;
  logic busy_o;

  bit micA[MaxN];
  bit rstA[MaxN];
  bit sA[MaxN];
  bit expClap[MaxN];
  bit expRej[MaxN];
  bit expBusy[MaxN];

  int n           = 0;
  int directedEnd = 0;
  int checks      = 0;
  int errors      = 0;
  int seenClap    = 0;
  int seenRej     = 0;

  clap_detector #(
    .CNT_W    (16),
    .MIN_HIGH (MinHigh),
    .MAX_HIGH (MaxHigh),
    .HOLDOFF  (Holdoff)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .mic_i    (mic_i),
    .clap_o   (clap_o),
    .reject_o (reject_o),
    .busy_o   (busy_o)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  // Append cnt cycles of the given mic level (reset low).
  task automatic addCycles(input int cnt, input bit m);
    for (int i = 0; i < cnt; i++) begin
      if (n < MaxN) begin
        micA[n] = m;
        rstA[n] = 1'b0;
        n++;
      end
    end
  endtask

  // Append one cycle with reset asserted and the given mic level.
  task automatic addReset(input bit m);
    if (n < MaxN) begin
      micA[n] = m;
      rstA[n] = 1'b1;
      n++;
    end
  endtask

  // The value the detector samples at edge k: mic delayed by two flops,
  // with either flop cleared by reset.
  task automatic computeSync();
    for (int k = 0; k < n; k++) begin
      bit s1;
      s1 = (k >= 2) ? (micA[k-2] && !rstA[k-2]) : 1'b0;
      sA[k] = (k >= 1 && !rstA[k-1]) ? s1 : 1'b0;
    end
  endtask

  // Hold-off starting after edge f. Returns the first edge at which the
  // detector is idle again (or a reset edge, handled by the caller).
  task automatic holdFrom(input int f, output int nextK);
    int h;
    int e;
    h = f;
    nextK = -1;
    while (nextK < 0) begin
      for (int i = 0; i < Holdoff && nextK < 0; i++) begin
        if (h + i >= n) nextK = n;
        else if (rstA[h+i]) nextK = h + i;
        else expBusy[h+i] = 1'b1;
      end
      if (nextK < 0) begin
        e = h + Holdoff;
        if (e >= n) nextK = n;
        else if (rstA[e]) nextK = e;
        else if (!sA[e]) nextK = e + 1;
        else begin
          while (e < n && !rstA[e] && sA[e]) begin
            expBusy[e] = 1'b1;
            e++;
          end
          if (e >= n) nextK = n;
          else if (rstA[e]) nextK = e;
          else h = e;
        end
      end
    end
  endtask

  // Classify each burst by its length and lay down the expected pulses.
  task automatic buildExpected();
    int k;
    int j;
    int len;
    k = 0;
    while (k < n) begin
      if (rstA[k] || !sA[k]) begin
        k++;
      end else begin
        j = k;
        while (j < n && !rstA[j] && sA[j]) begin
          expBusy[j] = 1'b1;
          j++;
        end
        len = j - k;
        if (len > MaxHigh) expRej[k + MaxHigh] = 1'b1;
        if (j >= n) k = n;
        else if (rstA[j]) k = j;
        else if (len >= MinHigh) begin
          if (len <= MaxHigh) expClap[j] = 1'b1;
          holdFrom(j, k);
        end else k = j + 1;
      end
    end
  endtask

  // Drive stimulus for cycle k half a period before its active edge.
  task automatic applyStimulus(input int k);
    @(negedge clk_i);
    mic_i = micA[k];
    rst_i = rstA[k];
  endtask

  // Compare all three outputs against the expected values for edge k.
  task automatic checkOutput(input int k);
    checks++;
    assert (clap_o === expClap[k]) else begin
      errors++;
      $error("[TB] FAIL clap cycle=%0d observed %b expected %b", k, clap_o, expClap[k]);
    end
    checks++;
    assert (reject_o === expRej[k]) else begin
      errors++;
      $error("[TB] FAIL reject cycle=%0d observed %b expected %b", k, reject_o, expRej[k]);
    end
    checks++;
    assert (busy_o === expBusy[k]) else begin
      errors++;
      $error("[TB] FAIL busy cycle=%0d observed %b expected %b", k, busy_o, expBusy[k]);
    end
    if (k < directedEnd) begin
      if (clap_o === 1'b1) seenClap++;
      if (reject_o === 1'b1) seenRej++;
    end
  endtask

  // Build the stream, derive expectations, then run and check every cycle.
  initial begin
    // Reset and settle.
    addReset(1'b0); addReset(1'b0); addReset(1'b0);
    addCycles(5, 1'b0);
    // 5-cycle burst: one clap.
    addCycles(5, 1'b1); addCycles(12, 1'b0);
    // Length boundaries: 2 drop, 3 clap, 8 clap, 9 reject.
    addCycles(2, 1'b1); addCycles(12, 1'b0);
    addCycles(3, 1'b1); addCycles(12, 1'b0);
    addCycles(8, 1'b1); addCycles(12, 1'b0);
    addCycles(9, 1'b1); addCycles(12, 1'b0);
    // Sustained 20-cycle noise: one reject.
    addCycles(20, 1'b1); addCycles(12, 1'b0);
    // Two 4-bursts, 2 apart: second lands in hold-off, one clap.
    addCycles(4, 1'b1); addCycles(2, 1'b0); addCycles(4, 1'b1); addCycles(14, 1'b0);
    // Two 4-bursts, 12 apart: two claps.
    addCycles(4, 1'b1); addCycles(12, 1'b0); addCycles(4, 1'b1); addCycles(14, 1'b0);
    // Reset on the 5th cycle of a 6-cycle burst; short tail is a glitch.
    addCycles(4, 1'b1); addReset(1'b1); addCycles(1, 1'b1); addCycles(14, 1'b0);
    // Single-cycle glitches every 3 cycles.
    for (int i = 0; i < 33; i++) begin
      addCycles(1, 1'b1); addCycles(2, 1'b0);
    end
    addCycles(12, 1'b0);
    directedEnd = n;

    // Random bursts and gaps around all the length boundaries.
    for (int i = 0; i < 80; i++) begin
      addCycles(int'($urandom_range(1, 12)), 1'b1);
      addCycles(int'($urandom_range(0, 14)), 1'b0);
    end
    for (int i = 0; i < 5; i++) rstA[$urandom_range(directedEnd, n - 1)] = 1'b1;
    addCycles(20, 1'b0);

    computeSync();
    buildExpected();

    $display("[TB] running %0d cycles", n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(k);
      @(posedge clk_i);
      #1;
      checkOutput(k);
    end

    checks++;
    assert (seenClap == 6) else begin
      errors++;
      $error("[TB] FAIL directedClaps observed %0d expected %0d", seenClap, 6);
    end
    checks++;
    assert (seenRej == 2) else begin
      errors++;
      $error("[TB] FAIL directedRejects observed %0d expected %0d", seenRej, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
